// File: rtl/gf24_pkg.sv
// Shared widths and bundle layout for the masked GF(2^4) factor generator.
// One bundle per share: {b[3:0], ff[1:0], f, h, l}, LSB first from l.
package gf24_pkg;
   localparam int SHARE_W  = 4;
   localparam int NSHARES  = 2;
   localparam int FF_W     = 2;
   localparam int BUNDLE_W = 9;
   localparam int L_OFF    = 0;
   localparam int H_OFF    = 1;
   localparam int F_OFF    = 2;
   localparam int FF_OFF   = 3;
   localparam int B_OFF    = 5;
endpackage

// File: rtl/gf24_factor.sv
// Combinational factoring of one 4-bit share into the multiplier's ff/f/h/l inputs.
// Sees a single share only, so no cross-share term can ever form here.
module gf24_factor
   import gf24_pkg::*;
(
   input  logic [SHARE_W-1:0] x,
   output logic [FF_W-1:0]    ff,
   output logic               f,
   output logic               h,
   output logic               l
);
   assign ff = x[3:2] ^ x[1:0];
   assign f  = ff[1] ^ ff[0];
   assign h  = x[3] ^ x[2];
   assign l  = x[1] ^ x[0];
endmodule

// File: rtl/gf24_factor_gen.sv
// Two-stage masked factor generator: stage 1 remasks both shares with rnd,
// stage 2 registers each share with its own factors for the shared multiplier.
module gf24_factor_gen
   import gf24_pkg::*;
#(
   parameter int unsigned REMASK = 1
)(
   input  logic               CLK,
   input  logic               RSTn,
   input  logic [SHARE_W-1:0] in_b0,
   input  logic [SHARE_W-1:0] in_b1,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SHARE_W-1:0] rnd,
   input  logic               rnd_valid,
   output logic               rnd_ack,
   input  logic               flush,
   output logic [SHARE_W-1:0] out_b0,
   output logic [SHARE_W-1:0] out_b1,
   output logic [FF_W-1:0]    out_ff0,
   output logic [FF_W-1:0]    out_ff1,
   output logic               out_f0,
   output logic               out_f1,
   output logic               out_h0,
   output logic               out_h1,
   output logic               out_l0,
   output logic               out_l1,
   output logic               out_valid,
   input  logic               out_ready
);
   logic [NSHARES-1:0][SHARE_W-1:0]  in_b, s1_d, s1_q;
   logic [NSHARES-1:0][BUNDLE_W-1:0] s2_d, s2_q;
   logic [2:1]                       vld_pipe;
   logic                             adv1, acc, rnd_ok;

   assign in_b   = {in_b1, in_b0};
   assign rnd_ok = (REMASK == 0) | rnd_valid;
   assign adv1   = !vld_pipe[2] | out_ready;
   assign in_ready = !flush & (!vld_pipe[1] | adv1);
   assign acc    = RSTn & in_valid & in_ready & rnd_ok;
   assign rnd_ack = (REMASK != 0) ? acc : 1'b0;

   // Both shares take the same rnd, so their XOR (the secret) is preserved.
   for (genvar s = 0; s < NSHARES; s++) begin : g_share
      logic [FF_W-1:0] ff;
      logic            f, h, l;
      assign s1_d[s] = (REMASK != 0) ? (in_b[s] ^ rnd) : in_b[s];
      gf24_factor u_factor (
         .x  (s1_q[s]),
         .ff (ff),
         .f  (f),
         .h  (h),
         .l  (l)
      );
      assign s2_d[s] = {s1_q[s], ff, f, h, l};
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else begin
         if (in_ready) vld_pipe[1] <= acc;
         if (adv1)     vld_pipe[2] <= vld_pipe[1];
         if (acc)      s1_q <= s1_d;
         if (adv1 && vld_pipe[1]) s2_q <= s2_d;
      end
   end

   assign out_valid = vld_pipe[2];
   assign out_b0  = s2_q[0][B_OFF +: SHARE_W];
   assign out_b1  = s2_q[1][B_OFF +: SHARE_W];
   assign out_ff0 = s2_q[0][FF_OFF +: FF_W];
   assign out_ff1 = s2_q[1][FF_OFF +: FF_W];
   assign out_f0  = s2_q[0][F_OFF];
   assign out_f1  = s2_q[1][F_OFF];
   assign out_h0  = s2_q[0][H_OFF];
   assign out_h1  = s2_q[1][H_OFF];
   assign out_l0  = s2_q[0][L_OFF];
   assign out_l1  = s2_q[1][L_OFF];
endmodule

// File: tb/tb_gf24_factor_gen.sv
// Randomized bench for gf24_factor_gen: queue scoreboard for a REMASK=1 and a
// REMASK=0 instance driven from the same stimulus, plus directed corner cases.
module tb_gf24_factor_gen;
   logic       CLK = 1'b0;
   logic       RSTn, in_valid, rnd_valid, flush, out_ready;
   logic [3:0] in_b0, in_b1, rnd;

   logic       in_ready, rnd_ack, out_valid;
   logic [3:0] out_b0, out_b1;
   logic [1:0] out_ff0, out_ff1;
   logic       out_f0, out_f1, out_h0, out_h1, out_l0, out_l1;

   logic       in_ready_nr, rnd_ack_nr, out_valid_nr;
   logic [3:0] out_b0_nr, out_b1_nr;
   logic [1:0] out_ff0_nr, out_ff1_nr;
   logic       out_f0_nr, out_f1_nr, out_h0_nr, out_h1_nr, out_l0_nr, out_l1_nr;

   int nvec = 0;
   int nerr = 0;

   always #5 CLK = ~CLK;

   gf24_factor_gen #(.REMASK(1)) dut (
      .CLK(CLK), .RSTn(RSTn), .in_b0(in_b0), .in_b1(in_b1), .in_valid(in_valid),
      .in_ready(in_ready), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack),
      .flush(flush), .out_b0(out_b0), .out_b1(out_b1), .out_ff0(out_ff0),
      .out_ff1(out_ff1), .out_f0(out_f0), .out_f1(out_f1), .out_h0(out_h0),
      .out_h1(out_h1), .out_l0(out_l0), .out_l1(out_l1), .out_valid(out_valid),
      .out_ready(out_ready));

   gf24_factor_gen #(.REMASK(0)) dut_nr (
      .CLK(CLK), .RSTn(RSTn), .in_b0(in_b0), .in_b1(in_b1), .in_valid(in_valid),
      .in_ready(in_ready_nr), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack_nr),
      .flush(flush), .out_b0(out_b0_nr), .out_b1(out_b1_nr), .out_ff0(out_ff0_nr),
      .out_ff1(out_ff1_nr), .out_f0(out_f0_nr), .out_f1(out_f1_nr), .out_h0(out_h0_nr),
      .out_h1(out_h1_nr), .out_l0(out_l0_nr), .out_l1(out_l1_nr),
      .out_valid(out_valid_nr), .out_ready(out_ready));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference factoring from the arithmetic definition: {ff, f, h, l}.
   function automatic logic [4:0] fac(input logic [3:0] x);
      int hi, lo, ff, f, h, l;
      hi = int'(x) / 4;  lo = int'(x) % 4;
      ff = hi ^ lo;
      f  = (ff / 2) ^ (ff % 2);
      h  = (hi / 2) ^ (hi % 2);
      l  = (lo / 2) ^ (lo % 2);
      return 5'(ff * 8 + f * 4 + h * 2 + l);
   endfunction

   typedef struct { logic [3:0] b0; logic [3:0] b1; } pair_t;
   pair_t q[$];
   pair_t qn[$];
   pair_t e;
   logic        acc, accn, stall;
   logic [17:0] saved;

   always @(negedge CLK) begin
      if (!RSTn) begin
         q.delete(); qn.delete(); stall = 1'b0;
         chk("ack_in_reset", 32'(rnd_ack), 0);
      end else if (flush) begin
         q.delete(); qn.delete(); stall = 1'b0;
         chk("ack_in_flush", 32'(rnd_ack), 0);
      end else begin
         acc  = in_valid & in_ready & rnd_valid;
         accn = in_valid & in_ready_nr;
         chk("rnd_ack", 32'(rnd_ack), 32'(acc));
         chk("rnd_ack_nr", 32'(rnd_ack_nr), 0);
         if (stall)
            chk("stall_stable", 32'({out_valid, out_b0, out_b1, out_ff0, out_ff1, out_f0,
                out_f1, out_h0, out_h1, out_l0}), 32'({1'b1, saved[17:1]}));
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
            else begin
               e = q.pop_front();
               chk("out_b0", 32'(out_b0), 32'(e.b0));
               chk("out_b1", 32'(out_b1), 32'(e.b1));
               chk("fac0", 32'({out_ff0, out_f0, out_h0, out_l0}), 32'(fac(e.b0)));
               chk("fac1", 32'({out_ff1, out_f1, out_h1, out_l1}), 32'(fac(e.b1)));
            end
         end
         stall = out_valid & !out_ready;
         saved = {out_b0, out_b1, out_ff0, out_ff1, out_f0, out_f1, out_h0, out_h1, out_l0, out_l1};
         if (acc) q.push_back('{in_b0 ^ rnd, in_b1 ^ rnd});
         if (out_valid_nr && out_ready) begin
            if (qn.size() == 0) chk("spurious_out_nr", 32'(out_valid_nr), 0);
            else begin
               e = qn.pop_front();
               chk("nr_b", 32'({out_b0_nr, out_b1_nr}), 32'({e.b0, e.b1}));
               chk("nr_fac", 32'({out_ff0_nr, out_f0_nr, out_h0_nr, out_l0_nr,
                   out_ff1_nr, out_f1_nr, out_h1_nr, out_l1_nr}), 32'({fac(e.b0), fac(e.b1)}));
            end
         end
         if (accn) qn.push_back('{in_b0, in_b1});
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_in();
      in_b0 = 4'($urandom);
      in_b1 = 4'($urandom);
      rnd   = 4'($urandom);
   endtask

   initial begin
      RSTn = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_b0 = '0; in_b1 = '0; rnd = '0;
      repeat (3) step();
      @(negedge CLK);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'({out_b0, out_b1, out_ff0, out_ff1, out_f0, out_h0, out_l0}), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      step();
      RSTn = 1'b1;

      // Known vector: A/3 remasked with 5
      step();
      in_b0 = 4'hA; in_b1 = 4'h3; rnd = 4'h5; in_valid = 1'b1; rnd_valid = 1'b1;
      @(negedge CLK);
      chk("vec_ack", 32'(rnd_ack), 1);
      step();
      in_valid = 1'b0;
      @(negedge CLK);
      chk("vec_lat1", 32'(out_valid), 0);
      step();
      @(negedge CLK);
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_b", 32'({out_b0, out_b1}), 32'h00F6);
      chk("vec_fac0", 32'({out_ff0, out_f0, out_h0, out_l0}), 32'b00000);
      chk("vec_fac1", 32'({out_ff1, out_f1, out_h1, out_l1}), 32'b11011);
      chk("vec_nr_b", 32'({out_b0_nr, out_b1_nr}), 32'h00A3);
      step();

      // Back-to-back stream of 16
      for (int i = 0; i < 16; i++) begin
         rand_in(); in_valid = 1'b1; rnd_valid = 1'b1;
         @(negedge CLK);
         chk("stream_ready", 32'(in_ready), 1);
         if (i >= 2) chk("stream_out_valid", 32'(out_valid), 1);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();

      // Backpressure for 5 cycles with operands offered
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         rand_in(); in_valid = 1'b1;
         @(negedge CLK);
         chk("bp_ready", 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
         step();
      end
      out_ready = 1'b1;
      @(negedge CLK);
      chk("bp_resume_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      repeat (4) step();

      // Randomness starvation mid-stream
      for (int c = 0; c < 4; c++) begin rand_in(); in_valid = 1'b1; step(); end
      rnd_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         rand_in();
         @(negedge CLK);
         if (c == 2) chk("starve_drained", 32'(out_valid), 0);
         step();
      end
      rnd_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin rand_in(); step(); end
      in_valid = 1'b0;
      repeat (4) step();

      // Random traffic with occasional flush
      for (int c = 0; c < 300; c++) begin
         rand_in();
         in_valid  = ($urandom % 4) != 0;
         rnd_valid = ($urandom % 5) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 40) == 0;
         step();
      end
      flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
      repeat (4) step();

      // Flush and then reset with both stages full
      for (int k = 0; k < 2; k++) begin
         out_ready = 1'b0; rnd_valid = 1'b1;
         for (int c = 0; c < 3; c++) begin rand_in(); in_valid = 1'b1; step(); end
         in_valid = 1'b0;
         if (k == 0) flush = 1'b1; else RSTn = 1'b0;
         step();
         flush = 1'b0; RSTn = 1'b1; out_ready = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk(k == 0 ? "flush_out_valid" : "reset_out_valid", 32'(out_valid), 0);
            chk(k == 0 ? "flush_out_valid_nr" : "reset_out_valid_nr", 32'(out_valid_nr), 0);
            step();
         end
      end

      repeat (4) step();
      chk("queue_empty", 32'(q.size()), 0);
      chk("queue_empty_nr", 32'(qn.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
